// File: rtl/moore_step_sequencer_if.sv
// Request channel for one requester of the step sequencer.
// Valid and target are held by the requester until it sees the single-cycle ready pulse.
interface moore_step_sequencer_if;
    logic       valid;
    logic [3:0] target;
    logic       ready;

    modport master (output valid, output target, input ready);
    modport slave  (input valid, input target, output ready);
endinterface

// File: rtl/moore_step_sequencer.sv
// Two-requester round-robin command sequencer for the 10-state ring Moore machine.
// Walks the machine to each accepted target by the shortest ring direction and mirrors its position.
module moore_step_sequencer #(
    parameter int STEP_GAP = 0,
    parameter int PARK_POS = 9,
    parameter int RING_LEN = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    moore_step_sequencer_if.slave        req0,
    moore_step_sequencer_if.slave        req1,
    output logic [1:0]                   W,
    output logic [3:0]                   pos,
    output logic                         busy,
    output logic                         grant,
    output logic                         done,
    output logic                         err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_GAP,
        ST_JUMP,
        ST_DONE
    } state_t;

    localparam logic [1:0] W_HOLD = 2'b00;
    localparam logic [1:0] W_DOWN = 2'b01;
    localparam logic [1:0] W_UP   = 2'b10;
    localparam logic [1:0] W_JUMP = 2'b11;

    localparam logic [3:0] PARK      = 4'(PARK_POS);
    localparam logic [3:0] RING_LAST = 4'(RING_LEN - 1);
    localparam logic [4:0] RING_LEN5 = 5'(RING_LEN);
    localparam logic [4:0] HALF_RING = 5'(RING_LEN / 2);
    localparam logic [3:0] GAP_LAST  = 4'((STEP_GAP > 0) ? (STEP_GAP - 1) : 0);

    state_t     r_state;
    state_t     w_stateNext;
    logic [1:0] r_w;
    logic [1:0] w_wNext;
    logic [3:0] r_pos;
    logic [3:0] w_posNext;
    logic [3:0] r_target;
    logic [3:0] w_targetNext;
    logic [3:0] r_gapCnt;
    logic [3:0] w_gapNext;
    logic [3:0] w_sel;
    logic       r_grant;
    logic       w_grantNext;
    logic       w_pick1;
    logic       w_ready0;
    logic       w_ready1;
    logic       w_err;

    // Position the machine reaches after applying step code w from position p.
    function automatic logic [3:0] applyStep(input logic [3:0] p, input logic [1:0] w);
        case (w)
            W_UP:    return (p >= RING_LAST) ? 4'd0 : p + 4'd1;
            W_DOWN:  return ((p == 4'd0) || (p > RING_LAST)) ? RING_LAST : p - 4'd1;
            W_JUMP:  return PARK;
            default: return p;
        endcase
    endfunction

    // Shortest-direction step toward ring target t; leaving park is always an up step.
    function automatic logic [1:0] stepToward(input logic [3:0] p, input logic [3:0] t);
        logic [4:0] upDist;
        if (p > RING_LAST) return W_UP;
        upDist = (t >= p) ? {1'b0, t - p} : ({1'b0, t} + RING_LEN5 - {1'b0, p});
        return (upDist <= HALF_RING) ? W_UP : W_DOWN;
    endfunction

    assign w_posNext = applyStep(r_pos, r_w);
    assign w_pick1   = req1.valid && (!req0.valid || !r_grant);
    assign w_sel     = w_pick1 ? req1.target : req0.target;

    // The step code is chosen one cycle ahead so that W leaves the register file.
    always_comb begin
        w_stateNext  = r_state;
        w_wNext      = W_HOLD;
        w_targetNext = r_target;
        w_grantNext  = r_grant;
        w_gapNext    = r_gapCnt;
        w_ready0     = 1'b0;
        w_ready1     = 1'b0;
        w_err        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req0.valid || req1.valid) begin
                    w_ready0     = !w_pick1;
                    w_ready1     = w_pick1;
                    w_grantNext  = w_pick1;
                    w_targetNext = w_sel;
                    if (w_sel > PARK) begin
                        w_err = 1'b1;
                    end else if (w_sel == r_pos) begin
                        w_stateNext = ST_DONE;
                    end else if (w_sel == PARK) begin
                        w_stateNext = ST_JUMP;
                        w_wNext     = W_JUMP;
                    end else begin
                        w_stateNext = ST_MOVE;
                        w_wNext     = stepToward(r_pos, w_sel);
                    end
                end
            end

            ST_JUMP: begin
                w_stateNext = ST_DONE;
            end

            ST_MOVE: begin
                if (w_posNext == r_target) begin
                    w_stateNext = ST_DONE;
                end else if (STEP_GAP > 0) begin
                    w_stateNext = ST_GAP;
                    w_gapNext   = 4'd0;
                end else begin
                    w_wNext = stepToward(w_posNext, r_target);
                end
            end

            ST_GAP: begin
                if (r_gapCnt == GAP_LAST) begin
                    w_stateNext = ST_MOVE;
                    w_wNext     = stepToward(r_pos, r_target);
                    w_gapNext   = 4'd0;
                end else begin
                    w_gapNext = r_gapCnt + 4'd1;
                end
            end

            ST_DONE: begin
                w_stateNext = ST_IDLE;
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Grant resets to 1 so that requester 0 wins the first contested cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_w      <= W_HOLD;
            r_pos    <= 4'd0;
            r_target <= 4'd0;
            r_grant  <= 1'b1;
            r_gapCnt <= 4'd0;
        end else begin
            r_state  <= w_stateNext;
            r_w      <= w_wNext;
            r_pos    <= w_posNext;
            r_target <= w_targetNext;
            r_grant  <= w_grantNext;
            r_gapCnt <= w_gapNext;
        end
    end

    assign req0.ready = w_ready0;
    assign req1.ready = w_ready1;
    assign W          = r_w;
    assign pos        = r_pos;
    assign grant      = r_grant;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign err        = w_err;

endmodule

// File: tb/tb_moore_step_sequencer.sv
// Scoreboard bench for moore_step_sequencer: one instance with no step gap, one with STEP_GAP=2.
// A path-level reference model queues the expected accept/step/done/err events; a monitor pops them.
module tb_moore_step_sequencer;

    localparam int GAP_A = 0;
    localparam int GAP_B = 2;

    localparam int KIND_ACC  = 0;
    localparam int KIND_STEP = 1;
    localparam int KIND_DONE = 2;
    localparam int KIND_ERR  = 3;

    typedef struct {
        int         kind;
        int         who;
        logic [1:0] w;
        logic [3:0] pos;
        int         rel;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cycle = 0;
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    logic       v0[2];
    logic       v1[2];
    logic [3:0] t0[2];
    logic [3:0] t1[2];
    logic       rdy0[2];
    logic       rdy1[2];
    logic [1:0] wOut[2];
    logic [3:0] posOut[2];
    logic       busyOut[2];
    logic       grantOut[2];
    logic       doneOut[2];
    logic       errOut[2];

    ev_t expQ[2][$];
    int  acceptCycle[2];
    int  mPos[2];
    int  mGrant[2];
    int  gapOf[2];

    moore_step_sequencer_if ifA0();
    moore_step_sequencer_if ifA1();
    moore_step_sequencer_if ifB0();
    moore_step_sequencer_if ifB1();

    assign ifA0.valid  = v0[0];
    assign ifA0.target = t0[0];
    assign rdy0[0]     = ifA0.ready;
    assign ifA1.valid  = v1[0];
    assign ifA1.target = t1[0];
    assign rdy1[0]     = ifA1.ready;
    assign ifB0.valid  = v0[1];
    assign ifB0.target = t0[1];
    assign rdy0[1]     = ifB0.ready;
    assign ifB1.valid  = v1[1];
    assign ifB1.target = t1[1];
    assign rdy1[1]     = ifB1.ready;

    moore_step_sequencer #(.STEP_GAP(GAP_A), .PARK_POS(9), .RING_LEN(9)) dutA (
        .clk   (clk),
        .reset (reset),
        .req0  (ifA0),
        .req1  (ifA1),
        .W     (wOut[0]),
        .pos   (posOut[0]),
        .busy  (busyOut[0]),
        .grant (grantOut[0]),
        .done  (doneOut[0]),
        .err   (errOut[0])
    );

    moore_step_sequencer #(.STEP_GAP(GAP_B), .PARK_POS(9), .RING_LEN(9)) dutB (
        .clk   (clk),
        .reset (reset),
        .req0  (ifB0),
        .req1  (ifB1),
        .W     (wOut[1]),
        .pos   (posOut[1]),
        .busy  (busyOut[1]),
        .grant (grantOut[1]),
        .done  (doneOut[1]),
        .err   (errOut[1])
    );

    task automatic checkValue(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic ev_t mkEv(input int kind, input int who, input logic [1:0] w,
                                 input int p, input int rel);
        ev_t e;
        e.kind = kind;
        e.who  = who;
        e.w    = w;
        e.pos  = 4'(p);
        e.rel  = rel;
        return e;
    endfunction

    // Reference model: walks the whole ring path for one accepted command.
    task automatic pushCommand(input int g, input int who, input int target);
        int p;
        int np;
        int r;
        int upDist;
        logic [1:0] w;
        expQ[g].push_back(mkEv(KIND_ACC, who, 2'b00, mPos[g], 0));
        mGrant[g] = who;
        if (target > 9) begin
            expQ[g].push_back(mkEv(KIND_ERR, who, 2'b00, mPos[g], 0));
            return;
        end
        if (target == mPos[g]) begin
            expQ[g].push_back(mkEv(KIND_DONE, who, 2'b00, target, 1));
            return;
        end
        if (target == 9) begin
            expQ[g].push_back(mkEv(KIND_STEP, who, 2'b11, mPos[g], 1));
            expQ[g].push_back(mkEv(KIND_DONE, who, 2'b00, 9, 2));
            mPos[g] = 9;
            return;
        end
        p = mPos[g];
        r = 1;
        while (p != target) begin
            if (p == 9) begin
                w  = 2'b10;
                np = 0;
            end else begin
                upDist = (target - p + 9) % 9;
                if (upDist <= 4) begin
                    w  = 2'b10;
                    np = (p + 1) % 9;
                end else begin
                    w  = 2'b01;
                    np = (p + 8) % 9;
                end
            end
            expQ[g].push_back(mkEv(KIND_STEP, who, w, p, r));
            p = np;
            r += (p == target) ? 1 : gapOf[g] + 1;
        end
        expQ[g].push_back(mkEv(KIND_DONE, who, 2'b00, target, r));
        mPos[g] = target;
    endtask

    task automatic checkOutput(input int g, input int kind, input int who, input logic [1:0] w,
                               input logic [3:0] p, input logic gr, input logic bz);
        ev_t e;
        int  rel;
        bit  ok;
        nChecks++;
        if (expQ[g].size() == 0) begin
            nFails++;
            $display("[TB] FAIL event inst%0d cycle %0d: got kind=%0d W=%b pos=%0d, expected no event",
                     g, cycle, kind, w, p);
            return;
        end
        e = expQ[g].pop_front();
        if (kind == KIND_ACC) acceptCycle[g] = cycle;
        rel = cycle - acceptCycle[g];
        ok  = (e.kind == kind) && (rel == e.rel);
        case (kind)
            KIND_ACC:  ok = ok && (who == e.who) && !bz;
            KIND_STEP: ok = ok && (w == e.w) && (p == e.pos) && bz;
            KIND_DONE: ok = ok && (p == e.pos) && (gr == 1'(e.who)) && bz;
            default:   ok = ok;
        endcase
        if (!ok) begin
            nFails++;
            $display("[TB] FAIL event inst%0d cycle %0d: got kind=%0d who=%0d W=%b pos=%0d rel=%0d grant=%b busy=%b, expected kind=%0d who=%0d W=%b pos=%0d rel=%0d",
                     g, cycle, kind, who, w, p, rel, gr, bz, e.kind, e.who, e.w, e.pos, e.rel);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gMon
        always @(negedge clk) begin
            if (!reset) begin
                expQ[g].delete();
            end else begin
                if (rdy0[g])          checkOutput(g, KIND_ACC,  0, wOut[g], posOut[g], grantOut[g], busyOut[g]);
                if (rdy1[g])          checkOutput(g, KIND_ACC,  1, wOut[g], posOut[g], grantOut[g], busyOut[g]);
                if (errOut[g])        checkOutput(g, KIND_ERR,  0, wOut[g], posOut[g], grantOut[g], busyOut[g]);
                if (wOut[g] != 2'b00) checkOutput(g, KIND_STEP, 0, wOut[g], posOut[g], grantOut[g], busyOut[g]);
                if (doneOut[g])       checkOutput(g, KIND_DONE, 0, wOut[g], posOut[g], grantOut[g], busyOut[g]);
            end
        end
    end

    task automatic waitReady(input int g, input int r);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            seen = (r == 0) ? rdy0[g] : rdy1[g];
        end
        nChecks++;
        if (!seen) begin
            nFails++;
            $display("[TB] FAIL handshake inst%0d req%0d: ready stayed 0 for 300 cycles, expected 1", g, r);
        end
        @(posedge clk);
        #1;
        if (r == 0) v0[g] = 1'b0;
        else        v1[g] = 1'b0;
    endtask

    task automatic waitIdle(input int g);
        for (int c = 0; c < 400 && expQ[g].size() != 0; c++) @(posedge clk);
        checkValue($sformatf("drain inst%0d pending events", g), expQ[g].size(), 0);
        @(posedge clk);
    endtask

    task automatic applyStimulus(input int g, input bit en0, input logic [3:0] tg0,
                                 input bit en1, input logic [3:0] tg1, input bit waitDone);
        int first;
        @(posedge clk);
        #1;
        if (en0 && en1) begin
            first = (mGrant[g] == 0) ? 1 : 0;
            pushCommand(g, first, (first == 1) ? int'(tg1) : int'(tg0));
            pushCommand(g, 1 - first, (first == 1) ? int'(tg0) : int'(tg1));
        end else if (en0) begin
            pushCommand(g, 0, int'(tg0));
        end else if (en1) begin
            pushCommand(g, 1, int'(tg1));
        end
        t0[g] = tg0;
        t1[g] = tg1;
        v0[g] = en0;
        v1[g] = en1;
        fork
            begin if (en0) waitReady(g, 0); end
            begin if (en1) waitReady(g, 1); end
        join
        if (waitDone) waitIdle(g);
    endtask

    function automatic logic [3:0] randTarget();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    task automatic randomRun(input int g, input int n);
        int pat;
        for (int i = 0; i < n; i++) begin
            pat = $urandom_range(0, 2);
            applyStimulus(g, pat != 1, randTarget(), pat != 0, randTarget(), 1'b1);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run not finished after 50000 cycles, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startPos;
        for (int g = 0; g < 2; g++) begin
            v0[g] = 1'b0;
            v1[g] = 1'b0;
            t0[g] = 4'd0;
            t1[g] = 4'd0;
            mPos[g] = 0;
            mGrant[g] = 1;
            acceptCycle[g] = 0;
        end
        gapOf[0] = GAP_A;
        gapOf[1] = GAP_B;

        repeat (3) @(posedge clk);
        #2;
        for (int g = 0; g < 2; g++) begin
            checkValue($sformatf("reset W inst%0d", g), wOut[g], 0);
            checkValue($sformatf("reset pos inst%0d", g), posOut[g], 0);
            checkValue($sformatf("reset busy inst%0d", g), busyOut[g], 0);
            checkValue($sformatf("reset done inst%0d", g), doneOut[g], 0);
            checkValue($sformatf("reset err inst%0d", g), errOut[g], 0);
            checkValue($sformatf("reset grant inst%0d", g), grantOut[g], 1);
            checkValue($sformatf("reset ready0 inst%0d", g), rdy0[g], 0);
            checkValue($sformatf("reset ready1 inst%0d", g), rdy1[g], 0);
        end
        reset = 1'b1;

        $display("[TB] no-gap instance: directed commands");
        applyStimulus(0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1);
        applyStimulus(0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1);
        applyStimulus(0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b1);
        applyStimulus(0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b1);
        applyStimulus(0, 1'b1, 4'd9, 1'b0, 4'd0, 1'b1);
        applyStimulus(0, 1'b1, 4'd2, 1'b0, 4'd0, 1'b1);

        $display("[TB] reset during a 4-step move");
        startPos = mPos[0];
        applyStimulus(0, 1'b1, 4'((startPos + 4) % 9), 1'b0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        checkValue("pos after first step", posOut[0], (startPos + 1) % 9);
        #1;
        reset = 1'b0;
        #1;
        checkValue("mid-move reset W", wOut[0], 0);
        checkValue("mid-move reset pos", posOut[0], 0);
        checkValue("mid-move reset busy", busyOut[0], 0);
        checkValue("mid-move reset done", doneOut[0], 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            mPos[g] = 0;
            mGrant[g] = 1;
            expQ[g].delete();
        end

        $display("[TB] both requesters valid after reset");
        applyStimulus(0, 1'b1, 4'd2, 1'b1, 4'd5, 1'b1);
        randomRun(0, 40);

        $display("[TB] gap instance: directed commands");
        applyStimulus(1, 1'b1, 4'd2, 1'b0, 4'd0, 1'b1);
        applyStimulus(1, 1'b0, 4'd0, 1'b1, 4'd2, 1'b1);
        applyStimulus(1, 1'b1, 4'd12, 1'b0, 4'd0, 1'b1);
        applyStimulus(1, 1'b1, 4'd9, 1'b0, 4'd0, 1'b1);
        applyStimulus(1, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1);
        applyStimulus(1, 1'b1, 4'd15, 1'b1, 4'd7, 1'b1);
        randomRun(1, 30);

        repeat (5) @(posedge clk);
        for (int g = 0; g < 2; g++) begin
            checkValue($sformatf("final pending events inst%0d", g), expQ[g].size(), 0);
            checkValue($sformatf("final busy inst%0d", g), busyOut[g], 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
